vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart to the VGA timing generator: samples h_sync/v_sync and 4:4:4 RGB at pixel rate and recovers pixel coordinates and a valid strobe.
- Measures line length and frame height, and declares lock after consecutive conforming frames.
- Used as an in-fabric loopback checker and as the capture front end for the frame-grab path.

Parameters:
- H_DISPLAY_INTERVAL, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC, 96, pixels of h_sync low
- H_BACK_PORCH, 48, pixels
- V_DISPLAY_INTERVAL, 480, active lines
- V_FRONT_PORCH, 10, lines
- V_SYNC, 2, lines of v_sync low
- V_BACK_PORCH, 33, lines
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- pixel_en  in  1  pixel-rate enable (25 MHz, one clk wide); all state advances only when high
- h_sync_in  in  1  active-low horizontal sync
- v_sync_in  in  1  active-low vertical sync
- red_in, green_in, blue_in  in  4 each  pixel colour
- h_position  out  12  recovered active column
- v_position  out  11  recovered active row
- pixel_valid  out  1  high for one pixel_en tick per active pixel while locked
- red_out, green_out, blue_out  out  4 each  registered colour, zero when pixel_valid low
- frame_start  out  1  one-tick pulse on each sampled v_sync falling edge
- line_length  out  12  last measured h_sync period in ticks
- frame_lines  out  11  last measured lines per frame
- locked  out  1  timing lock
- timing_error  out  1  one-tick pulse on any mismatch while locked

Behaviour:
- Reset: all outputs 0. Counters 0, FSM SEARCH, line_seen 0.
- Sampling: h_sync_in and v_sync_in registered on pixel_en. A falling edge is sampled prev=1, cur=0. All events are evaluated on the same pixel_en tick.
- h_cnt (12b):
  - Set to 0 on an h_sync fall; otherwise +1 per tick.
  - Saturates at 4095, with no wrap.
- Line measurement, on an h_sync fall:
  - line_length <= h_cnt+1 (saturated). Not updated on the first fall after reset.
  - line_seen <= 1.
  - line_err is set when line_seen is 1 and line_length != H_TOTAL.
- v_cnt (11b):
  - +1 on each h_sync fall, saturating at 2047.
  - Set to 0 on a v_sync fall.
  - When both falls occur on the same tick, v_sync wins: v_cnt = 0.
- Frame measurement, on a v_sync fall:
  - frame_lines <= v_cnt + (1 if an h_sync fall occurs on the same tick), saturated.
  - frame_start pulses.
- Active window:
  - h_act = h_cnt in [H_SYNC+H_BACK_PORCH, H_SYNC+H_BACK_PORCH+H_DISPLAY_INTERVAL).
  - v_act = v_cnt in [V_SYNC+V_BACK_PORCH, V_SYNC+V_BACK_PORCH+V_DISPLAY_INTERVAL).
  - h_position = h_cnt-(H_SYNC+H_BACK_PORCH); v_position = v_cnt-(V_SYNC+V_BACK_PORCH).
  - Both positions hold their last value outside the window.
- Output latency: registered outputs reflect the sample from the same pixel_en tick. They are valid on the clk after that tick and hold until the next tick.
- pixel_valid = locked & h_act & v_act.
- Lock FSM, evaluated on v_sync falls:
  - SEARCH: first v_sync fall -> TRACK; good=0; clear frame_err.
  - TRACK: frame is good if frame_lines == V_TOTAL and frame_err == 0.
    - Good frame: good+1; if good+1 == LOCK_FRAMES -> LOCKED.
    - Bad frame: good=0.
    - frame_err then clears.
  - LOCKED, mismatch cases:
    - line_err at any h_sync fall: timing_error pulse, -> TRACK, good=0, locked drops on the same tick.
    - frame_lines != V_TOTAL at a v_sync fall: same response as line_err.
  - Loss of sync: no h_sync fall for 4095 ticks (h_cnt saturated) -> SEARCH, line_seen=0. A timing_error pulse is issued only if the FSM was LOCKED.
- frame_err: set by line_err in any state; cleared on a v_sync fall.
- locked = (state == LOCKED).
- Reset mid-frame: FSM returns to SEARCH. No pulse outputs on the reset cycle. Lock requires LOCK_FRAMES full frames after the next v_sync fall.

Optional Feature:
- Macro VGA_SYNC_MONITOR_CHECKSUM_EN adds output frame_checksum (16b).
  - Running sum, modulo 2^16, of {red_in,green_in,blue_in} (12b, zero-extended) over every tick where h_act & v_act, regardless of lock.
  - The sum is latched to frame_checksum and cleared on each v_sync fall; a pixel on that same tick is not included.
  - frame_checksum resets to 0.
- Without the macro: port and logic absent.

Test Plan:
- Drive from vga generator with defaults, constant RGB 0xF00 -> after 2nd v_sync fall following the first one, locked=1.
  - Thereafter line_length=800 and frame_lines=525.
  - 640x480 pixel_valid pulses per frame, with h_position 0..639 and v_position 0..479.
  - red_out=F during valid pulses; 0 elsewhere.
- While locked, stretch one line by 1 tick (801) -> timing_error pulses on that line's closing h_sync fall and locked=0.
  - Relock after 2 clean frames (the damaged frame does not count).
- Remove h_sync toggling for 5000 ticks while locked -> SEARCH, one timing_error, locked=0, line_length not updated by the first fall on resumption.
- Force h_sync fall and v_sync fall on same tick after 524 prior h_sync falls -> frame_lines=525, v_cnt=0.
- Assert reset mid-active-line -> all outputs 0 next clk, no pulses.
  - Lock regained exactly LOCK_FRAMES frames after the next v_sync fall.
- With VGA_SYNC_MONITOR_CHECKSUM_EN, RGB constant 0x001 -> frame_checksum = 307200 mod 65536 = 0xB000 at each frame_start.

Source files
------------

// File: rtl/vga_sync_monitor_if.sv
// ============================================================================
// Module      : vga_sync_monitor_if
// Description : Video bundle between a VGA timing source (master) and the
//               vga_sync_monitor (slave). Carries the pixel-rate enable,
//               active-low syncs and 4:4:4 colour towards the monitor and the
//               recovered coordinates, measurements and status back.
//               frame_checksum exists only when VGA_SYNC_MONITOR_CHECKSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_monitor_if;
    // source -> monitor
    logic        pixel_en;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [3:0]  red_in;
    logic [3:0]  green_in;
    logic [3:0]  blue_in;
    // monitor -> consumer
    logic [11:0] h_position;
    logic [10:0] v_position;
    logic        pixel_valid;
    logic [3:0]  red_out;
    logic [3:0]  green_out;
    logic [3:0]  blue_out;
    logic        frame_start;
    logic [11:0] line_length;
    logic [10:0] frame_lines;
    logic        locked;
    logic        timing_error;
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
    logic [15:0] frame_checksum;
`endif

    modport master (
        output pixel_en, h_sync_in, v_sync_in, red_in, green_in, blue_in,
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
        input  frame_checksum,
`endif
        input  h_position, v_position, pixel_valid, red_out, green_out,
               blue_out, frame_start, line_length, frame_lines, locked,
               timing_error
    );

    modport slave (
        input  pixel_en, h_sync_in, v_sync_in, red_in, green_in, blue_in,
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
        output frame_checksum,
`endif
        output h_position, v_position, pixel_valid, red_out, green_out,
               blue_out, frame_start, line_length, frame_lines, locked,
               timing_error
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// ============================================================================
// Module      : vga_sync_monitor
// Description : Receive-side VGA timing checker. Samples h/v sync and RGB on
//               each pixel_en tick, recovers the active pixel coordinates,
//               measures line length and frame height and declares lock after
//               LOCK_FRAMES consecutive conforming frames.
// Ports       : clk   - system clock
//               reset - synchronous, active-high
//               vid   - vga_sync_monitor_if.slave (pixel_en, syncs, RGB in;
//                       position, pixel_valid, RGB out, frame_start,
//                       line_length, frame_lines, locked, timing_error)
// Options     : VGA_SYNC_MONITOR_CHECKSUM_EN adds vid.frame_checksum, the
//               16-bit sum of active-window RGB over the previous frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_monitor #(
    parameter int H_DISPLAY_INTERVAL = 640,
    parameter int H_FRONT_PORCH      = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BACK_PORCH       = 48,
    parameter int V_DISPLAY_INTERVAL = 480,
    parameter int V_FRONT_PORCH      = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BACK_PORCH       = 33,
    parameter int LOCK_FRAMES        = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_sync_monitor_if.slave vid
);
    localparam logic [11:0] C_H_TOTAL = 12'(H_DISPLAY_INTERVAL + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH);
    localparam logic [10:0] C_V_TOTAL = 11'(V_DISPLAY_INTERVAL + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH);
    localparam logic [11:0] C_H_START = 12'(H_SYNC + H_BACK_PORCH);
    localparam logic [11:0] C_H_END   = 12'(H_SYNC + H_BACK_PORCH + H_DISPLAY_INTERVAL);
    localparam logic [10:0] C_V_START = 11'(V_SYNC + V_BACK_PORCH);
    localparam logic [10:0] C_V_END   = 11'(V_SYNC + V_BACK_PORCH + V_DISPLAY_INTERVAL);
    localparam logic [11:0] C_H_MAX   = 12'hFFF;
    localparam logic [10:0] C_V_MAX   = 11'h7FF;
    localparam logic [3:0]  C_LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        hs_prev_q, vs_prev_q;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        line_seen_q, line_seen_d;
    logic        frame_err_q, frame_err_d;
    logic [11:0] h_pos_q, h_pos_d, line_len_q, line_len_d;
    logic [10:0] v_pos_q, v_pos_d, frame_lines_q, frame_lines_d;
    logic        valid_q, valid_d, fstart_q, terr_q, terr_d, locked_q, locked_d;
    logic [11:0] rgb_q, rgb_d;

    logic        h_fall, v_fall, line_err, sync_lost, h_act, v_act;
    logic [11:0] h_meas;
    logic [10:0] v_meas;

    // Edges compare the previous registered sample with the live input, so
    // every event is seen on the pixel_en tick that carries the new level.
    assign h_fall = hs_prev_q & ~vid.h_sync_in;
    assign v_fall = vs_prev_q & ~vid.v_sync_in;

    assign h_meas   = (h_cnt_q == C_H_MAX) ? C_H_MAX : h_cnt_q + 12'd1;
    assign v_meas   = (h_fall && v_cnt_q != C_V_MAX) ? v_cnt_q + 11'd1 : v_cnt_q;
    assign line_err = h_fall & line_seen_q & (h_meas != C_H_TOTAL);

    always_comb begin
        h_cnt_d = h_fall ? 12'd0 : h_meas;
        v_cnt_d = v_cnt_q;
        if (v_fall)                         v_cnt_d = 11'd0;   // v_sync wins a tie
        else if (h_fall && v_cnt_q != C_V_MAX) v_cnt_d = v_cnt_q + 11'd1;
    end

    // Saturated counter means no line start for 4095 ticks.
    assign sync_lost = ~h_fall & (h_cnt_d == C_H_MAX);
    assign h_act     = (h_cnt_d >= C_H_START) && (h_cnt_d < C_H_END);
    assign v_act     = (v_cnt_d >= C_V_START) && (v_cnt_d < C_V_END);

    // Lock FSM: next state and the timing_error strobe.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        terr_d  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (v_fall) begin
                    state_d = ST_TRACK;
                    good_d  = 4'd0;
                end
            end
            ST_TRACK: begin
                if (v_fall) begin
                    // a line error closing the last line still spoils the frame
                    if (v_meas == C_V_TOTAL && !(frame_err_q | line_err)) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == C_LOCK_N) state_d = ST_LOCKED;
                    end else begin
                        good_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_err || (v_fall && v_meas != C_V_TOTAL)) begin
                    terr_d  = 1'b1;
                    state_d = ST_TRACK;
                    good_d  = 4'd0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 4'd0;
            end
        endcase
        if (sync_lost) begin
            state_d = ST_SEARCH;
            good_d  = 4'd0;
            terr_d  = (state_q == ST_LOCKED);
        end
    end

    always_comb begin
        line_seen_d   = sync_lost ? 1'b0 : (line_seen_q | h_fall);
        frame_err_d   = v_fall ? 1'b0 : (frame_err_q | line_err);
        line_len_d    = (h_fall && line_seen_q) ? h_meas : line_len_q;
        frame_lines_d = v_fall ? v_meas : frame_lines_q;
        locked_d      = (state_d == ST_LOCKED);
        valid_d       = locked_d & h_act & v_act;
        rgb_d         = valid_d ? {vid.red_in, vid.green_in, vid.blue_in} : 12'd0;
        h_pos_d       = h_act ? h_cnt_d - C_H_START : h_pos_q;
        v_pos_d       = v_act ? v_cnt_d - C_V_START : v_pos_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEARCH;
            good_q  <= 4'd0;
        end else if (vid.pixel_en) begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 11'd0;
            line_seen_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            h_pos_q       <= 12'd0;
            v_pos_q       <= 11'd0;
            line_len_q    <= 12'd0;
            frame_lines_q <= 11'd0;
            valid_q       <= 1'b0;
            fstart_q      <= 1'b0;
            terr_q        <= 1'b0;
            locked_q      <= 1'b0;
            rgb_q         <= 12'd0;
        end else if (vid.pixel_en) begin
            hs_prev_q     <= vid.h_sync_in;
            vs_prev_q     <= vid.v_sync_in;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_seen_q   <= line_seen_d;
            frame_err_q   <= frame_err_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            valid_q       <= valid_d;
            fstart_q      <= v_fall;
            terr_q        <= terr_d;
            locked_q      <= locked_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vid.h_position   = h_pos_q;
    assign vid.v_position   = v_pos_q;
    assign vid.pixel_valid  = valid_q;
    assign vid.red_out      = rgb_q[11:8];
    assign vid.green_out    = rgb_q[7:4];
    assign vid.blue_out     = rgb_q[3:0];
    assign vid.frame_start  = fstart_q;
    assign vid.line_length  = line_len_q;
    assign vid.frame_lines  = frame_lines_q;
    assign vid.locked       = locked_q;
    assign vid.timing_error = terr_q;

`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, cksum_q, cksum_d;

    // The v_sync-fall tick closes the frame: its own pixel is not summed.
    always_comb begin
        sum_d   = sum_q;
        cksum_d = cksum_q;
        if (v_fall) begin
            cksum_d = sum_q;
            sum_d   = 16'd0;
        end else if (h_act && v_act) begin
            sum_d = sum_q + {4'd0, vid.red_in, vid.green_in, vid.blue_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= 16'd0;
            cksum_q <= 16'd0;
        end else if (vid.pixel_en) begin
            sum_q   <= sum_d;
            cksum_q <= cksum_d;
        end
    end

    assign vid.frame_checksum = cksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// ============================================================================
// Module      : tb_vga_sync_monitor
// Description : Frame-level directed bench for vga_sync_monitor using a
//               reduced timing (15 x 8 total, 8 x 4 active) so that whole
//               frames, relock sequences and sync loss fit in a short run.
//               Each table record drives one frame (optionally preceded by
//               idle ticks, stretched, shortened or interrupted by a reset)
//               and lists the expected status at the end of that frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_monitor;
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 4, VF = 1, VS = 1, VB = 2;
    localparam int LF = 2;
    localparam int HT = HD + HF + HS + HB;   // 15
    localparam int HA = HS + HB;             // first active column
    localparam int VA = VS + VB;             // first active line
    localparam int NV = 19;

    logic clk = 1'b0;
    logic reset;

    vga_sync_monitor_if vif();

    vga_sync_monitor #(
        .H_DISPLAY_INTERVAL (HD), .H_FRONT_PORCH (HF), .H_SYNC (HS), .H_BACK_PORCH (HB),
        .V_DISPLAY_INTERVAL (VD), .V_FRONT_PORCH (VF), .V_SYNC (VS), .V_BACK_PORCH (VB),
        .LOCK_FRAMES        (LF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idle;
        int         nlines;
        int         stretch_line;
        int         rst_line;
        int         rst_x;
        logic [11:0] rgb;
        int         exp_locked;
        int         exp_te;
        int         exp_fs;
        int         exp_valid;
        int         exp_ll;
        int         exp_fl;
        int         exp_ll_first;
        int         exp_ck;
    } vec_t;

    vec_t tab [NV];

    int errors = 0;
    int checks = 0;
    int st_te, st_fs, st_valid, st_pix_err, st_ll_first, st_ck_first;

    function automatic vec_t mk(int idle, int nl, int sl, int rl, int rx, logic [11:0] rgb,
                                int lk, int te, int fs, int va, int ll, int fl, int llf, int ck);
        vec_t v;
        v.idle = idle; v.nlines = nl; v.stretch_line = sl; v.rst_line = rl; v.rst_x = rx;
        v.rgb = rgb; v.exp_locked = lk; v.exp_te = te; v.exp_fs = fs; v.exp_valid = va;
        v.exp_ll = ll; v.exp_fl = fl; v.exp_ll_first = llf; v.exp_ck = ck;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pixel_en tick: inputs set on the falling edge, outputs sampled 1 ns
    // after the rising edge that consumes them, enable dropped for the next clk.
    task automatic drive_tick(input logic hs, input logic vs, input logic [11:0] rgb,
                              input int x, input int y);
        logic [11:0] rgb_o;
        @(negedge clk);
        vif.pixel_en  = 1'b1;
        vif.h_sync_in = hs;
        vif.v_sync_in = vs;
        {vif.red_in, vif.green_in, vif.blue_in} = rgb;
        @(posedge clk);
        #1;
        rgb_o = {vif.red_out, vif.green_out, vif.blue_out};
        if (vif.timing_error) st_te++;
        if (vif.frame_start)  st_fs++;
        if (vif.pixel_valid) begin
            st_valid++;
            if (int'(vif.h_position) != x - HA || int'(vif.v_position) != y - VA || rgb_o != rgb)
                st_pix_err++;
        end else if (rgb_o != 12'd0) begin
            st_pix_err++;
        end
        @(negedge clk);
        vif.pixel_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        int nz;
        nz = int'(|{vif.h_position, vif.v_position, vif.pixel_valid, vif.red_out,
                    vif.green_out, vif.blue_out, vif.frame_start, vif.line_length,
                    vif.frame_lines, vif.locked, vif.timing_error});
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
        nz = nz | int'(|vif.frame_checksum);
`endif
        check(name, nz, 0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset        = 1'b1;
        vif.pixel_en = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int   w;
        v = tab[idx];
        st_te = 0; st_fs = 0; st_valid = 0; st_pix_err = 0;
        st_ll_first = -1; st_ck_first = -1;
        for (int i = 0; i < v.idle; i++) drive_tick(1'b1, 1'b1, v.rgb, -1000, -1000);
        for (int y = 0; y < v.nlines; y++) begin
            w = (y == v.stretch_line) ? HT + 1 : HT;
            for (int x = 0; x < w; x++) begin
                if (y == v.rst_line && x == v.rst_x)
                    do_reset($sformatf("rec%0d_midline_reset_zero", idx));
                drive_tick(x >= HS, y >= VS, v.rgb, x, y);
                if (x == 0 && y == 0) begin
                    st_ll_first = int'(vif.line_length);
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
                    st_ck_first = int'(vif.frame_checksum);
`endif
                end
            end
        end
        check($sformatf("rec%0d_locked", idx), int'(vif.locked), v.exp_locked);
        check($sformatf("rec%0d_timing_error_pulses", idx), st_te, v.exp_te);
        check($sformatf("rec%0d_frame_start_pulses", idx), st_fs, v.exp_fs);
        check($sformatf("rec%0d_pixel_valid_count", idx), st_valid, v.exp_valid);
        check($sformatf("rec%0d_pixel_pos_rgb_errs", idx), st_pix_err, 0);
        check($sformatf("rec%0d_line_length", idx), int'(vif.line_length), v.exp_ll);
        check($sformatf("rec%0d_frame_lines", idx), int'(vif.frame_lines), v.exp_fl);
        if (v.exp_ll_first >= 0)
            check($sformatf("rec%0d_line_length_first_tick", idx), st_ll_first, v.exp_ll_first);
`ifdef VGA_SYNC_MONITOR_CHECKSUM_EN
        if (v.exp_ck >= 0)
            check($sformatf("rec%0d_frame_checksum", idx), st_ck_first, v.exp_ck);
`endif
    endtask

    initial begin
        //            idle  nl  str  rl rx  rgb      lk te fs val ll fl  llf  ck
        tab[0]  = mk(3,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 1, -1, -1);    // first v fall: SEARCH->TRACK
        tab[1]  = mk(0,    8, -1, -1, -1, 12'h0A5, 0, 0, 1, 0,  15, 8, -1, 57344); // good=1; sum of frame 0
        tab[2]  = mk(0,    8, -1, -1, -1, 12'h123, 1, 0, 1, 32, 15, 8, -1, 5280);  // locks
        tab[3]  = mk(0,    8, -1, -1, -1, 12'hF00, 1, 0, 1, 32, 15, 8, -1, 9312);
        tab[4]  = mk(0,    8,  3, -1, -1, 12'h3C7, 0, 1, 1, 8,  15, 8, -1, -1);    // 16-tick line
        tab[5]  = mk(0,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 8, -1, -1);    // damaged frame rejected
        tab[6]  = mk(0,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 8, -1, -1);
        tab[7]  = mk(0,    8, -1, -1, -1, 12'hF00, 1, 0, 1, 32, 15, 8, -1, -1);    // relocked
        tab[8]  = mk(0,    7, -1, -1, -1, 12'hF00, 1, 0, 1, 32, 15, 8, -1, -1);    // short frame
        tab[9]  = mk(0,    8, -1, -1, -1, 12'hF00, 0, 1, 1, 0,  15, 7, -1, -1);    // 7 lines seen
        tab[10] = mk(0,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 8, -1, -1);
        tab[11] = mk(0,    8, -1, -1, -1, 12'hF00, 1, 0, 1, 32, 15, 8, -1, -1);
        tab[12] = mk(0,    8, -1,  4,  8, 12'hF00, 0, 0, 1, 11, 15, 0, -1, -1);    // reset mid line
        tab[13] = mk(0,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 4, -1, -1);
        tab[14] = mk(0,    8, -1, -1, -1, 12'hF00, 0, 0, 1, 0,  15, 8, -1, -1);
        tab[15] = mk(0,    8, -1, -1, -1, 12'hF00, 1, 0, 1, 32, 15, 8, -1, -1);
        tab[16] = mk(5000, 8, -1, -1, -1, 12'h001, 0, 1, 1, 0,  15, 8, 15, 57344); // sync loss
        tab[17] = mk(0,    8, -1, -1, -1, 12'h001, 0, 0, 1, 0,  15, 8, -1, -1);
        tab[18] = mk(0,    8, -1, -1, -1, 12'h001, 1, 0, 1, 32, 15, 8, -1, 32);

        reset         = 1'b1;
        vif.pixel_en  = 1'b0;
        vif.h_sync_in = 1'b1;
        vif.v_sync_in = 1'b1;
        {vif.red_in, vif.green_in, vif.blue_in} = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state_outputs");
        check("reset_state_locked", int'(vif.locked), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_frame(i);

        // Outputs must hold between pixel_en ticks.
        begin
            int ll0, lk0;
            ll0 = int'(vif.line_length);
            lk0 = int'(vif.locked);
            repeat (4) @(posedge clk);
            #1;
            check("hold_no_enable_line_length", int'(vif.line_length), ll0);
            check("hold_no_enable_locked", int'(vif.locked), 1);
            check("hold_locked_unchanged", lk0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
